// File: rtl/ec_control_unit.sv
// ec_control_unit -- FSM controller / instruction sequencer for the 8-bit
// accumulator processor. Holds PC and IR, drives the memory address and write
// strobe, and steers the accumulator datapath. Each instruction runs
// fetch -> decode -> execute. IN waits for a fresh rising edge on Enter.
//
// Ports
//   Clock    in   system clock, rising edge
//   Reset    in   synchronous, active-high
//   MemData  in   [DATA_W] combinational memory read data for Addr
//   Enter    in   user confirm for IN (level; a rising edge is consumed)
//   Aeq0     in   datapath flag A == 0
//   Apos     in   datapath flag A > 0 (signed)
//   Addr     out  [ADDR_W] memory address
//   MemWr    out  memory write strobe (A written at the clock edge)
//   Aload    out  accumulator load enable
//   Asel     out  [2] A source: 00 add/sub, 01 input, 10 memory
//   sub      out  0 add, 1 subtract
//   Halt     out  high in HALT
//   PC       out  [ADDR_W] program counter (debug)
//   State    out  [4] current state code (debug)
module ec_control_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] MemData,
  input  logic              Enter,
  input  logic              Aeq0,
  input  logic              Apos,
  output logic [ADDR_W-1:0] Addr,
  output logic              MemWr,
  output logic              Aload,
  output logic [1:0]        Asel,
  output logic              sub,
  output logic              Halt,
  output logic [ADDR_W-1:0] PC,
  output logic [3:0]        State
);

  localparam logic [3:0] S_START  = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_LOAD   = 4'd3;
  localparam logic [3:0] S_STORE  = 4'd4;
  localparam logic [3:0] S_ADD    = 4'd5;
  localparam logic [3:0] S_SUB    = 4'd6;
  localparam logic [3:0] S_INPUT  = 4'd7;
  localparam logic [3:0] S_JZ     = 4'd8;
  localparam logic [3:0] S_JPOS   = 4'd9;
  localparam logic [3:0] S_HALT   = 4'd10;

  logic [3:0]        state, nxt;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic              enterq;
  logic              enter_rise;
  logic [ADDR_W-1:0] opnd;
  logic [2:0]        opc;

  assign opnd       = ir[ADDR_W-1:0];
  assign opc        = ir[DATA_W-1 -: 3];
  // Enter held high across INPUT entry must not complete IN, so only a
  // 0->1 transition seen against last cycle's sample counts.
  assign enter_rise = Enter & ~enterq;
  assign PC         = pc;
  assign State      = state;

  always_comb begin
    nxt = S_START;
    case (state)
      S_START:  nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (opc)
          3'b000:  nxt = S_LOAD;
          3'b001:  nxt = S_STORE;
          3'b010:  nxt = S_ADD;
          3'b011:  nxt = S_SUB;
          3'b100:  nxt = S_INPUT;
          3'b101:  nxt = S_JZ;
          3'b110:  nxt = S_JPOS;
          default: nxt = S_HALT;
        endcase
      end
      S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: nxt = S_FETCH;
      S_INPUT:  nxt = enter_rise ? S_FETCH : S_INPUT;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_START;  // illegal codes recover through START
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= S_START;
      pc     <= '0;
      ir     <= '0;
      enterq <= 1'b0;
    end else begin
      state  <= nxt;
      enterq <= Enter;
      case (state)
        S_FETCH: begin
          ir <= MemData;
          pc <= pc + 1'b1;  // wraps naturally at 2^ADDR_W
        end
        S_JZ:    if (Aeq0) pc <= opnd;
        S_JPOS:  if (Apos) pc <= opnd;
        default: ;
      endcase
    end
  end

  always_comb begin
    Addr  = '0;
    MemWr = 1'b0;
    Aload = 1'b0;
    Asel  = 2'b00;
    sub   = 1'b0;
    Halt  = 1'b0;
    case (state)
      S_FETCH:  Addr = pc;
      S_DECODE: Addr = opnd;
      S_LOAD:   begin Addr = opnd; Asel = 2'b10; Aload = 1'b1; end
      S_STORE:  begin Addr = opnd; MemWr = 1'b1; end
      S_ADD:    begin Addr = opnd; Aload = 1'b1; end
      S_SUB:    begin Addr = opnd; sub = 1'b1; Aload = 1'b1; end
      S_INPUT:  begin Asel = 2'b01; Aload = enter_rise; end
      S_JZ,
      S_JPOS:   Addr = opnd;
      S_HALT:   Halt = 1'b1;
      default:  ;
    endcase
    // Reset must win over any in-flight store or load this same edge.
    if (Reset) begin
      MemWr = 1'b0;
      Aload = 1'b0;
    end
  end

endmodule

// File: tb/tb_ec_control_unit.sv
// Directed bench for ec_control_unit. A single stimulus process owns a small
// accumulator/memory model: it captures the DUT strobes just before each edge
// and applies load/store effects just after it.
module tb_ec_control_unit;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] MemData;
  logic       Enter = 1'b0;
  logic       Aeq0, Apos;
  logic [4:0] Addr;
  logic       MemWr, Aload, sub, Halt;
  logic [1:0] Asel;
  logic [4:0] PC;
  logic [3:0] State;

  logic [7:0] mem [32];
  logic [7:0] A = 8'h00;
  logic [7:0] inval = 8'h00;
  int checks = 0;
  int failures = 0;

  assign MemData = mem[Addr];
  assign Aeq0    = (A == 8'h00);
  assign Apos    = (A != 8'h00) && !A[7];

  always #5 Clock = ~Clock;

  ec_control_unit #(.DATA_W(8), .ADDR_W(5)) dut (
    .Clock(Clock), .Reset(Reset), .MemData(MemData), .Enter(Enter),
    .Aeq0(Aeq0), .Apos(Apos), .Addr(Addr), .MemWr(MemWr), .Aload(Aload),
    .Asel(Asel), .sub(sub), .Halt(Halt), .PC(PC), .State(State)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample strobes before the edge, apply datapath effects after.
  task automatic tick();
    logic ld, wr, sb;
    logic [1:0] sel;
    logic [4:0] ad;
    logic [7:0] md;
    #1;
    ld = Aload; wr = MemWr; sel = Asel; sb = sub; ad = Addr; md = MemData;
    @(posedge Clock);
    #1;
    if (ld) begin
      case (sel)
        2'b00:   A = sb ? A - md : A + md;
        2'b01:   A = inval;
        2'b10:   A = md;
        default: A = 8'hxx;
      endcase
    end
    if (wr) mem[ad] = A;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  // Hold reset for two cycles, then release; DUT sits in START afterwards.
  task automatic do_reset();
    Reset = 1'b1;
    ticks(2);
    Reset = 1'b0;
    #1;
  endtask

  initial begin
    clr_mem();
    // ---- reset state ----
    ticks(2);
    chk("rst_state", State, 0);
    chk("rst_pc", PC, 0);
    chk("rst_memwr", MemWr, 0);
    chk("rst_aload", Aload, 0);
    chk("rst_halt", Halt, 0);

    // ---- IN / STORE 31 / HALT ----
    mem[0] = 8'h9E; mem[1] = 8'h3F; mem[2] = 8'hE0;
    inval = 8'h2A; A = 8'h00;
    do_reset();
    chk("start_state", State, 0);
    tick();
    chk("fetch_state", State, 1);
    chk("fetch_addr", Addr, 0);
    ticks(2);
    chk("in_state", State, 7);
    chk("in_asel", Asel, 1);
    chk("in_wait_aload", Aload, 0);
    tick();
    chk("in_still_wait", State, 7);
    Enter = 1'b1; #1;
    chk("in_enter_aload", Aload, 1);
    tick();
    chk("in_done_fetch", State, 1);
    chk("in_a_value", A, 8'h2A);
    Enter = 1'b0;
    ticks(2);
    chk("st_state", State, 4);
    chk("st_memwr", MemWr, 1);
    chk("st_addr", Addr, 31);
    tick();
    chk("st_mem31", mem[31], 8'h2A);
    ticks(2);
    chk("halt_state", State, 10);
    chk("halt_out", Halt, 1);
    chk("halt_pc", PC, 3);
    Enter = 1'b1; tick();
    Enter = 1'b0; tick();
    chk("halt_ign_enter", State, 10);
    Reset = 1'b1; #1;
    chk("halt_rst_memwr", MemWr, 0);
    chk("halt_rst_aload", Aload, 0);
    tick();
    chk("halt_rst_state", State, 0);
    chk("halt_rst_pc", PC, 0);

    // ---- LOAD 10 / ADD 11 / SUB 10 ----
    clr_mem();
    mem[0] = 8'h0A; mem[1] = 8'h4B; mem[2] = 8'h6A; mem[3] = 8'hE0;
    mem[10] = 8'd5; mem[11] = 8'd3;
    A = 8'h00;
    do_reset();
    ticks(3);
    chk("ld_state", State, 3);
    chk("ld_asel", Asel, 2);
    chk("ld_aload", Aload, 1);
    chk("ld_addr", Addr, 10);
    tick();
    chk("ld_a", A, 5);
    chk("ld_next_fetch", State, 1);
    ticks(2);
    chk("add_state", State, 5);
    chk("add_asel", Asel, 0);
    chk("add_sub", sub, 0);
    chk("add_addr", Addr, 11);
    tick();
    chk("add_a", A, 8);
    ticks(2);
    chk("sub_state", State, 6);
    chk("sub_sub", sub, 1);
    chk("sub_aload", Aload, 1);
    tick();
    chk("sub_a", A, 3);
    chk("sub_next_fetch", State, 1);
    chk("sub_pc", PC, 3);

    // ---- JZ / JPOS taken and not taken, PC wrap ----
    clr_mem();
    mem[12] = 8'h00; mem[13] = 8'h07; mem[14] = 8'h80;
    mem[0]  = 8'h0C;  // LOAD 12 -> A=0
    mem[1]  = 8'hB4;  // JZ 20 (taken)
    mem[20] = 8'h0D;  // LOAD 13 -> A=7
    mem[21] = 8'hB4;  // JZ 20 (not taken)
    mem[22] = 8'h0E;  // LOAD 14 -> A=0x80
    mem[23] = 8'hC2;  // JPOS 2 (not taken)
    mem[24] = 8'h0D;  // LOAD 13 -> A=7
    mem[25] = 8'hDE;  // JPOS 30 (taken)
    mem[30] = 8'h0D;  // LOAD 13
    mem[31] = 8'h0C;  // LOAD 12, PC wraps after this
    A = 8'h55;
    do_reset();
    tick();
    ticks(3);
    chk("jz0_pre_pc", PC, 1);
    ticks(3);
    chk("jz_taken_pc", PC, 20);
    chk("jz_taken_addr", Addr, 20);
    ticks(6);
    chk("jz_not_taken_pc", PC, 22);
    ticks(6);
    chk("jpos_neg_pc", PC, 24);
    ticks(6);
    chk("jpos_taken_pc", PC, 30);
    ticks(3);
    chk("wrap_pre_pc", PC, 31);
    ticks(3);
    chk("wrap_pc", PC, 0);
    chk("wrap_state", State, 1);
    chk("wrap_addr", Addr, 0);

    // ---- Enter held high before IN ----
    clr_mem();
    mem[0] = 8'h80; mem[1] = 8'hE0;
    inval = 8'h55; A = 8'h00;
    Enter = 1'b1;
    do_reset();
    ticks(3);
    chk("hold_state", State, 7);
    chk("hold_aload", Aload, 0);
    tick();
    chk("hold_state2", State, 7);
    Enter = 1'b0;
    tick();
    chk("hold_drop_state", State, 7);
    chk("hold_a_unchanged", A, 0);
    Enter = 1'b1; #1;
    chk("hold_rise_aload", Aload, 1);
    tick();
    chk("hold_done_state", State, 1);
    chk("hold_a", A, 8'h55);
    chk("hold_single_aload", Aload, 0);

    // ---- Reset during STORE exec ----
    Enter = 1'b0;
    clr_mem();
    mem[0] = 8'h25;  // STORE 5
    A = 8'h33;
    do_reset();
    ticks(3);
    chk("strst_state", State, 4);
    chk("strst_memwr_pre", MemWr, 1);
    Reset = 1'b1; #1;
    chk("strst_memwr", MemWr, 0);
    tick();
    chk("strst_state_after", State, 0);
    chk("strst_pc_after", PC, 0);
    chk("strst_no_write", mem[5], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound: the directed sequence is a few hundred cycles at most.
  initial begin
    #100000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
